// File: rtl/day3_pkg.sv
// Shared day-3 definitions: ASCII codes and decoder state encoding,
// reused by the byte decoder, later engine stages and their benches.
package day3_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PEND_EOL,
    ST_DONE
  } dec_state_t;

  function automatic logic is_ascii_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/day3_byte_decoder.sv
// Day-3 byte decoder: turns an ASCII valid/ready byte stream into registered
// digit / end_of_line pulses, tracks line count, flags bad input, signals done.
module day3_byte_decoder
  import day3_pkg::*;
#(
  parameter int unsigned LINE_W          = 16,
  parameter int unsigned MAX_LINE_DIGITS = 255
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [3:0]        digit,
  output logic              digit_valid,
  output logic              end_of_line,
  output logic              done,
  output logic              error,
  output logic [LINE_W-1:0] line_count
);

  localparam int unsigned    LEN_W   = $clog2(MAX_LINE_DIGITS + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LINE_DIGITS);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LINE_DIGITS + 1);

  dec_state_t        r_state;
  logic              r_ready;
  logic [3:0]        r_digit;
  logic              r_digit_valid;
  logic              r_eol;
  logic              r_done;
  logic              r_error;
  logic [LINE_W-1:0] r_line_count;
  logic [LEN_W-1:0]  r_len;

  logic             w_accept;
  logic             w_is_digit;
  logic             w_is_lf;
  logic             w_is_cr;
  logic             w_is_bad;
  logic [LEN_W-1:0] w_len_inc;
  logic             w_close_line;

  always_comb begin
    w_accept   = in_valid & r_ready;
    w_is_digit = is_ascii_digit(in_data);
    w_is_lf    = (in_data == ASCII_LF);
    w_is_cr    = (in_data == ASCII_CR);
    w_is_bad   = ~w_is_digit & ~w_is_lf & ~w_is_cr;
    w_len_inc  = (r_len == LEN_SAT) ? r_len : r_len + 1'b1;
    // Any non-digit final byte closes an open line just like LF does.
    w_close_line = w_accept & ~w_is_digit & (r_len != '0) & (w_is_lf | in_last);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state       <= ST_RUN;
      r_ready       <= 1'b0;
      r_digit       <= '0;
      r_digit_valid <= 1'b0;
      r_eol         <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_line_count  <= '0;
      r_len         <= '0;
    end else begin
      r_digit_valid <= 1'b0;
      r_eol         <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_is_digit) begin
              r_digit       <= 4'(in_data - ASCII_0);
              r_digit_valid <= 1'b1;
              r_len         <= w_len_inc;
              if (w_len_inc > LEN_MAX) r_error <= 1'b1;
              if (in_last) begin
                r_state <= ST_PEND_EOL;
                r_ready <= 1'b0;
              end
            end else begin
              if (w_is_bad) r_error <= 1'b1;
              if (w_close_line) begin
                r_eol        <= 1'b1;
                r_line_count <= r_line_count + 1'b1;
                r_len        <= '0;
              end
              if (in_last) begin
                r_state <= ST_DONE;
                r_ready <= 1'b0;
              end
            end
          end
        end
        // Final digit was just emitted; its eol must follow one cycle later.
        ST_PEND_EOL: begin
          r_ready      <= 1'b0;
          r_eol        <= 1'b1;
          r_line_count <= r_line_count + 1'b1;
          r_len        <= '0;
          r_state      <= ST_DONE;
        end
        ST_DONE: begin
          r_ready <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign in_ready    = r_ready;
  assign digit       = r_digit;
  assign digit_valid = r_digit_valid;
  assign end_of_line = r_eol;
  assign done        = r_done;
  assign error       = r_error;
  assign line_count  = r_line_count;

endmodule

// File: tb/tb_day3_byte_decoder.sv
// Scoreboard bench for day3_byte_decoder: directed byte strings, expected
// digit/eol events queued by the stimulus and popped by a negedge monitor.
module tb_day3_byte_decoder;
  import day3_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        sel3 = 1'b0;

  logic        v1, v3, w_rdy;
  logic        in_ready, digit_valid, end_of_line, done, error;
  logic [3:0]  digit;
  logic [15:0] line_count;
  logic        in_ready3, digit_valid3, end_of_line3, done3, error3;
  logic [3:0]  digit3;
  logic [15:0] line_count3;

  assign v1    = in_valid & ~sel3;
  assign v3    = in_valid & sel3;
  assign w_rdy = sel3 ? in_ready3 : in_ready;

  always #5 clock = ~clock;

  day3_byte_decoder #(.LINE_W(16), .MAX_LINE_DIGITS(255)) u_dut (
    .clock(clock), .clear(clear), .in_data(in_data), .in_valid(v1),
    .in_last(in_last), .in_ready(in_ready), .digit(digit),
    .digit_valid(digit_valid), .end_of_line(end_of_line), .done(done),
    .error(error), .line_count(line_count)
  );

  day3_byte_decoder #(.LINE_W(16), .MAX_LINE_DIGITS(3)) u_dut3 (
    .clock(clock), .clear(clear), .in_data(in_data), .in_valid(v3),
    .in_last(in_last), .in_ready(in_ready3), .digit(digit3),
    .digit_valid(digit_valid3), .end_of_line(end_of_line3), .done(done3),
    .error(error3), .line_count(line_count3)
  );

  typedef struct {
    bit         is_eol;
    logic [3:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_d(input int d);
    ev_t e;
    e.is_eol = 1'b0;
    e.d      = 4'(d);
    exp_q.push_back(e);
  endtask

  task automatic push_eol();
    ev_t e;
    e.is_eol = 1'b1;
    e.d      = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: every output pulse of the main DUT is matched against the queue.
  always @(negedge clock) begin
    ev_t e;
    if (digit_valid && end_of_line) begin
      n_vec++;
      n_err++;
      $display("FAIL coincident: digit_valid=1 end_of_line=1, required not both at %0t", $time);
    end else if (digit_valid || end_of_line) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: digit_valid=%0d end_of_line=%0d digit=%0d, required none at %0t",
                 digit_valid, end_of_line, digit, $time);
      end else begin
        e = exp_q.pop_front();
        chk("event_is_eol", int'(end_of_line), int'(e.is_eol));
        if (!e.is_eol) chk("digit_value", int'(digit), int'(e.d));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send(input logic [7:0] b, input logic last);
    in_data  = b;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (w_rdy) break;
      @(negedge clock);
    end
    if (!w_rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: in_ready=0 after 20 cycles, required 1 at %0t", $time);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end else begin
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic send_str(input string s, input logic last);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last && (i == s.len() - 1));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    string s;
    repeat (3) @(negedge clock);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_digit_valid", int'(digit_valid), 0);
    chk("reset_eol", int'(end_of_line), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_line_count", int'(line_count), 0);
    chk("reset_digit", int'(digit), 0);
    clear = 1'b0;
    @(negedge clock);
    chk("ready_after_clear", int'(in_ready), 1);

    // Long line, no in_last
    s = "987654321111111";
    for (int i = 0; i < s.len(); i++) push_d(int'(s[i]) - 48);
    push_eol();
    send_str("987654321111111\n", 1'b0);
    repeat (2) @(negedge clock);
    chk("t1_line_count", int'(line_count), 1);
    chk("t1_error", int'(error), 0);
    chk("t1_done", int'(done), 0);
    chk("t1_ready", int'(in_ready), 1);

    // Blank lines and CR do not pulse
    do_clear();
    push_d(1); push_d(2); push_eol(); push_d(3); push_d(4); push_eol();
    send_str("12\n\n\r\n34", 1'b1);
    repeat (2) @(negedge clock);
    chk("t2_line_count", int'(line_count), 2);
    chk("t2_done", int'(done), 1);
    chk("t2_error", int'(error), 0);
    chk("t2_ready", int'(in_ready), 0);
    in_data  = "3";
    in_valid = 1'b1;
    repeat (4) @(negedge clock);
    in_valid = 1'b0;
    chk("t2_ignored_line_count", int'(line_count), 2);

    // Illegal byte mid-line
    do_clear();
    push_d(1); push_d(2); push_eol();
    send("1", 1'b0);
    chk("t3_error_before", int'(error), 0);
    send("a", 1'b0);
    chk("t3_error_after", int'(error), 1);
    send("2", 1'b0);
    send(ASCII_LF, 1'b0);
    chk("t3_line_count", int'(line_count), 1);
    chk("t3_error_sticky", int'(error), 1);

    // in_last on a digit: pending eol cycle
    do_clear();
    push_d(5); push_eol();
    send("5", 1'b1);
    chk("t4_ready_pend", int'(in_ready), 0);
    chk("t4_done_pend", int'(done), 0);
    @(negedge clock);
    chk("t4_eol", int'(end_of_line), 1);
    chk("t4_ready_eol", int'(in_ready), 0);
    chk("t4_done_eol", int'(done), 0);
    @(negedge clock);
    chk("t4_done", int'(done), 1);
    chk("t4_line_count", int'(line_count), 1);

    // in_last on an illegal byte closes the open line
    do_clear();
    push_d(8); push_eol();
    send("8", 1'b0);
    send("x", 1'b1);
    chk("t5_error", int'(error), 1);
    chk("t5_line_count", int'(line_count), 1);
    chk("t5_done_early", int'(done), 0);
    @(negedge clock);
    chk("t5_done", int'(done), 1);

    // in_last on a blank line: no pulse, done next cycle
    do_clear();
    send(ASCII_LF, 1'b1);
    chk("t6_line_count", int'(line_count), 0);
    chk("t6_done_early", int'(done), 0);
    @(negedge clock);
    chk("t6_done", int'(done), 1);

    // clear while in PEND_EOL discards the eol
    do_clear();
    push_d(7);
    send("7", 1'b1);
    clear = 1'b1;
    @(negedge clock);
    chk("t7_eol", int'(end_of_line), 0);
    chk("t7_line_count", int'(line_count), 0);
    chk("t7_ready_in_clear", int'(in_ready), 0);
    clear = 1'b0;
    @(negedge clock);
    chk("t7_ready_after", int'(in_ready), 1);
    chk("t7_done", int'(done), 0);
    @(negedge clock);
    chk("t7_no_late_eol_count", int'(line_count), 0);

    // Over-long line on the MAX_LINE_DIGITS=3 instance
    sel3 = 1'b1;
    do_clear();
    send_str("123", 1'b0);
    chk("t8_error_at_max", int'(error3), 0);
    send("4", 1'b0);
    chk("t8_error_over", int'(error3), 1);
    send(ASCII_LF, 1'b0);
    chk("t8_line_count", int'(line_count3), 1);
    chk("t8_error_sticky", int'(error3), 1);
    sel3 = 1'b0;

    repeat (3) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
